// File: rtl/ahb_outputstage_arbiter_itcm.sv
// ahb_outputstage_arbiter_itcm: ICODE/DCODE output-stage arbiter for the shared ITCM AHB-Lite slave.
// Define ARB_ROUND_ROBIN_EN to alternate simultaneous grants; the default build gives DCODE fixed priority.
module ahb_outputstage_arbiter_itcm #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL_ICODE,
    input  logic [ADDR_WIDTH-1:0] HADDR_ICODE,
    input  logic [1:0]            HTRANS_ICODE,
    input  logic                  HWRITE_ICODE,
    input  logic [2:0]            HSIZE_ICODE,
    input  logic [DATA_WIDTH-1:0] HWDATA_ICODE,
    input  logic                  HSEL_DCODE,
    input  logic [ADDR_WIDTH-1:0] HADDR_DCODE,
    input  logic [1:0]            HTRANS_DCODE,
    input  logic                  HWRITE_DCODE,
    input  logic [2:0]            HSIZE_DCODE,
    input  logic [DATA_WIDTH-1:0] HWDATA_DCODE,
    input  logic                  HREADYOUT_S,
    output logic                  ACTIVE_Outputstage_ICODE,
    output logic                  ACTIVE_Outputstage_DCODE,
    output logic                  HSEL_S,
    output logic [ADDR_WIDTH-1:0] HADDR_S,
    output logic [1:0]            HTRANS_S,
    output logic                  HWRITE_S,
    output logic [2:0]            HSIZE_S,
    output logic [DATA_WIDTH-1:0] HWDATA_S,
    output logic                  HREADY_S
);
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;
    logic       req_i, req_d, lock_i, lock_d, sel_i, sel_d;
    logic [1:0] both_pick, arb_next, addr_owner, addr_owner_q, data_owner_d, data_owner_q;
    assign req_i  = HSEL_ICODE & HTRANS_ICODE[1];
    assign req_d  = HSEL_DCODE & HTRANS_DCODE[1];
    // A burst in progress (SEQ or BUSY) keeps the slave until its master stops selecting it.
    assign lock_i = (addr_owner_q == OWN_I) & HSEL_ICODE & HTRANS_ICODE[0];
    assign lock_d = (addr_owner_q == OWN_D) & HSEL_DCODE & HTRANS_DCODE[0];
`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] last_grant_q, last_grant_d;
    assign both_pick    = (last_grant_q == OWN_D) ? OWN_I : OWN_D;
    assign last_grant_d = !HREADYOUT_S ? last_grant_q :
                          (sel_i && HTRANS_ICODE == 2'b10) ? OWN_I :
                          (sel_d && HTRANS_DCODE == 2'b10) ? OWN_D : last_grant_q;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) last_grant_q <= OWN_I;
        else          last_grant_q <= last_grant_d;
    end
`else
    assign both_pick = OWN_D;
`endif
    assign arb_next = lock_i ? OWN_I :
                      lock_d ? OWN_D :
                      (req_i & req_d) ? both_pick :
                      req_d ? OWN_D :
                      req_i ? OWN_I : OWN_NONE;
    // Reset gates the combinational path so nothing reaches the slave while held in reset.
    assign addr_owner = !HRESETn ? OWN_NONE : HREADYOUT_S ? arb_next : addr_owner_q;
    assign sel_i      = addr_owner == OWN_I;
    assign sel_d      = addr_owner == OWN_D;
    assign data_owner_d = !HREADYOUT_S ? data_owner_q :
                          (sel_i & HTRANS_ICODE[1]) ? OWN_I :
                          (sel_d & HTRANS_DCODE[1]) ? OWN_D : OWN_NONE;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_owner_q <= OWN_NONE;
            data_owner_q <= OWN_NONE;
        end else begin
            addr_owner_q <= addr_owner;
            data_owner_q <= data_owner_d;
        end
    end
    always_comb begin
        HSEL_S   = sel_i ? HSEL_ICODE   : sel_d ? HSEL_DCODE   : 1'b0;
        HADDR_S  = sel_i ? HADDR_ICODE  : sel_d ? HADDR_DCODE  : '0;
        HTRANS_S = sel_i ? HTRANS_ICODE : sel_d ? HTRANS_DCODE : 2'b00;
        HWRITE_S = sel_i ? HWRITE_ICODE : sel_d ? HWRITE_DCODE : 1'b0;
        HSIZE_S  = sel_i ? HSIZE_ICODE  : sel_d ? HSIZE_DCODE  : 3'b000;
        HWDATA_S = (data_owner_q == OWN_I) ? HWDATA_ICODE :
                   (data_owner_q == OWN_D) ? HWDATA_DCODE : '0;
    end
    assign ACTIVE_Outputstage_ICODE = sel_i;
    assign ACTIVE_Outputstage_DCODE = sel_d;
    assign HREADY_S                 = HREADYOUT_S;
endmodule

// File: tb/tb_ahb_outputstage_arbiter_itcm.sv
// tb_ahb_outputstage_arbiter_itcm: scoreboard bench for the ITCM output-stage arbiter.
module tb_ahb_outputstage_arbiter_itcm;
    logic        clk = 1'b0;
    logic        HRESETn, HSEL_ICODE, HWRITE_ICODE, HSEL_DCODE, HWRITE_DCODE, HREADYOUT_S;
    logic [31:0] HADDR_ICODE, HWDATA_ICODE, HADDR_DCODE, HWDATA_DCODE, HADDR_S, HWDATA_S;
    logic [1:0]  HTRANS_ICODE, HTRANS_DCODE, HTRANS_S;
    logic [2:0]  HSIZE_ICODE, HSIZE_DCODE, HSIZE_S;
    logic        ACT_I, ACT_D, HSEL_S, HWRITE_S, HREADY_S;
    logic [72:0] obs, e;
    logic [72:0] sb[$];
    int          nchk = 0, nerr = 0;

    typedef struct packed {
        logic        rn, rdy, si;
        logic [1:0]  ti;
        logic [31:0] ai;
        logic        wi;
        logic [31:0] di;
        logic        sd;
        logic [1:0]  td;
        logic [31:0] ad;
        logic        wd;
        logic [31:0] dd;
        logic [72:0] ex;
    } stp_t;

    always #5 clk = ~clk;

    ahb_outputstage_arbiter_itcm dut (
        .HCLK(clk), .HRESETn(HRESETn),
        .HSEL_ICODE(HSEL_ICODE), .HADDR_ICODE(HADDR_ICODE), .HTRANS_ICODE(HTRANS_ICODE),
        .HWRITE_ICODE(HWRITE_ICODE), .HSIZE_ICODE(HSIZE_ICODE), .HWDATA_ICODE(HWDATA_ICODE),
        .HSEL_DCODE(HSEL_DCODE), .HADDR_DCODE(HADDR_DCODE), .HTRANS_DCODE(HTRANS_DCODE),
        .HWRITE_DCODE(HWRITE_DCODE), .HSIZE_DCODE(HSIZE_DCODE), .HWDATA_DCODE(HWDATA_DCODE),
        .HREADYOUT_S(HREADYOUT_S),
        .ACTIVE_Outputstage_ICODE(ACT_I), .ACTIVE_Outputstage_DCODE(ACT_D),
        .HSEL_S(HSEL_S), .HADDR_S(HADDR_S), .HTRANS_S(HTRANS_S), .HWRITE_S(HWRITE_S),
        .HSIZE_S(HSIZE_S), .HWDATA_S(HWDATA_S), .HREADY_S(HREADY_S)
    );

    assign obs = {HSEL_S, HTRANS_S, HADDR_S, HWRITE_S, HSIZE_S, HWDATA_S, ACT_I, ACT_D};

    // Expected slave-side view; every master drives word size, so HSIZE_S is word whenever someone owns.
    function automatic logic [72:0] ex(input logic s, input logic [1:0] t, input logic [31:0] a,
                                       input logic w, input logic [31:0] d, input logic ai, input logic ad);
        ex = {s, t, a, w, ((ai | ad) ? 3'b010 : 3'b000), d, ai, ad};
    endfunction

    function automatic stp_t mk(input logic rn, input logic rdy,
                                input logic si, input logic [1:0] ti, input logic [31:0] ai, input logic wi, input logic [31:0] di,
                                input logic sd, input logic [1:0] td, input logic [31:0] ad, input logic wd, input logic [31:0] dd,
                                input logic [72:0] x);
        mk = '{rn, rdy, si, ti, ai, wi, di, sd, td, ad, wd, dd, x};
    endfunction

    task automatic apply(input stp_t s);
        HRESETn = s.rn; HREADYOUT_S = s.rdy;
        HSEL_ICODE = s.si; HTRANS_ICODE = s.ti; HADDR_ICODE = s.ai; HWRITE_ICODE = s.wi; HWDATA_ICODE = s.di;
        HSEL_DCODE = s.sd; HTRANS_DCODE = s.td; HADDR_DCODE = s.ad; HWRITE_DCODE = s.wd; HWDATA_DCODE = s.dd;
        sb.push_back(s.ex);
    endtask

    task automatic test_reset;
        stp_t s[$];
        s.push_back(mk(0, 1, 1, 2'b10, 32'h8000, 0, 32'h0, 0, 2'b00, 32'h0, 0, 32'h0, ex(0, 2'b00, 0, 0, 0, 0, 0)));
        s.push_back(mk(1, 1, 0, 2'b00, 32'h0, 0, 32'h0, 0, 2'b00, 32'h0, 0, 32'h0, ex(0, 2'b00, 0, 0, 0, 0, 0)));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front();
            nchk++;
            if (obs !== e) begin nerr++; $display("FAIL reset[%0d]: got %h expected %h", i, obs, e); end
            @(posedge clk); #1;
        end
        HREADYOUT_S = 1'b0; #1;
        nchk++;
        if (HREADY_S !== 1'b0) begin nerr++; $display("FAIL hready_low: got %b expected 0", HREADY_S); end
        HREADYOUT_S = 1'b1; #1;
        nchk++;
        if (HREADY_S !== 1'b1) begin nerr++; $display("FAIL hready_high: got %b expected 1", HREADY_S); end
    endtask

    task automatic test_single;
        stp_t s[$];
        s.push_back(mk(1, 1, 1, 2'b10, 32'h8000, 0, 32'h1111, 0, 2'b00, 32'h0, 0, 32'h0, ex(1, 2'b10, 32'h8000, 0, 0, 1, 0)));
        s.push_back(mk(1, 1, 0, 2'b00, 32'h0, 0, 32'h1111, 0, 2'b00, 32'h0, 0, 32'h0, ex(0, 2'b00, 0, 0, 32'h1111, 0, 0)));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front();
            nchk++;
            if (obs !== e) begin nerr++; $display("FAIL single[%0d]: got %h expected %h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_both;
        stp_t s[$];
        s.push_back(mk(1, 1, 1, 2'b10, 32'h8004, 0, 32'h1234, 1, 2'b10, 32'h8100, 1, 32'h0, ex(1, 2'b10, 32'h8100, 1, 0, 0, 1)));
        s.push_back(mk(1, 1, 1, 2'b10, 32'h8004, 0, 32'h1234, 0, 2'b00, 32'h0, 0, 32'hA5A5_A5A5, ex(1, 2'b10, 32'h8004, 0, 32'hA5A5_A5A5, 1, 0)));
        s.push_back(mk(1, 1, 0, 2'b00, 32'h0, 0, 32'h1234, 0, 2'b00, 32'h0, 0, 32'h0, ex(0, 2'b00, 0, 0, 32'h1234, 0, 0)));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front();
            nchk++;
            if (obs !== e) begin nerr++; $display("FAIL both[%0d]: got %h expected %h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_burst;
        stp_t s[$];
        s.push_back(mk(1, 1, 1, 2'b10, 32'h8200, 0, 32'h1234, 1, 2'b10, 32'h9000, 1, 32'h0, ex(1, 2'b10, 32'h9000, 1, 0, 0, 1)));
        s.push_back(mk(1, 1, 1, 2'b10, 32'h8200, 0, 32'h1234, 1, 2'b11, 32'h9004, 1, 32'hD0, ex(1, 2'b11, 32'h9004, 1, 32'hD0, 0, 1)));
        s.push_back(mk(1, 1, 1, 2'b10, 32'h8200, 0, 32'h1234, 1, 2'b11, 32'h9008, 1, 32'hD1, ex(1, 2'b11, 32'h9008, 1, 32'hD1, 0, 1)));
        s.push_back(mk(1, 1, 1, 2'b10, 32'h8200, 0, 32'h1234, 1, 2'b11, 32'h900C, 1, 32'hD2, ex(1, 2'b11, 32'h900C, 1, 32'hD2, 0, 1)));
        s.push_back(mk(1, 1, 1, 2'b10, 32'h8200, 0, 32'h1234, 0, 2'b00, 32'h0, 0, 32'hD3, ex(1, 2'b10, 32'h8200, 0, 32'hD3, 1, 0)));
        s.push_back(mk(1, 1, 0, 2'b00, 32'h0, 0, 32'h1234, 0, 2'b00, 32'h0, 0, 32'h0, ex(0, 2'b00, 0, 0, 32'h1234, 0, 0)));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front();
            nchk++;
            if (obs !== e) begin nerr++; $display("FAIL burst[%0d]: got %h expected %h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wait;
        stp_t s[$];
        s.push_back(mk(1, 1, 0, 2'b00, 32'h0, 0, 32'h1234, 1, 2'b10, 32'hA000, 1, 32'h0, ex(1, 2'b10, 32'hA000, 1, 0, 0, 1)));
        s.push_back(mk(1, 0, 1, 2'b10, 32'hB000, 0, 32'h1234, 1, 2'b00, 32'hA000, 1, 32'hCAFE, ex(1, 2'b00, 32'hA000, 1, 32'hCAFE, 0, 1)));
        s.push_back(mk(1, 0, 1, 2'b10, 32'hB000, 0, 32'h1234, 1, 2'b00, 32'hA000, 1, 32'hCAFE, ex(1, 2'b00, 32'hA000, 1, 32'hCAFE, 0, 1)));
        s.push_back(mk(1, 1, 1, 2'b10, 32'hB000, 0, 32'h1234, 1, 2'b00, 32'hA000, 1, 32'hCAFE, ex(1, 2'b10, 32'hB000, 0, 32'hCAFE, 1, 0)));
        s.push_back(mk(1, 1, 0, 2'b00, 32'h0, 0, 32'h1234, 0, 2'b00, 32'h0, 0, 32'h0, ex(0, 2'b00, 0, 0, 32'h1234, 0, 0)));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front();
            nchk++;
            if (obs !== e) begin nerr++; $display("FAIL wait[%0d]: got %h expected %h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        stp_t s[$];
`ifdef ARB_ROUND_ROBIN_EN
        s.push_back(mk(1, 1, 1, 2'b10, 32'hC000, 0, 32'h1234, 1, 2'b10, 32'hD000, 0, 32'h5678, ex(1, 2'b10, 32'hD000, 0, 0, 0, 1)));
        s.push_back(mk(1, 1, 1, 2'b10, 32'hC000, 0, 32'h1234, 1, 2'b10, 32'hD004, 0, 32'h5678, ex(1, 2'b10, 32'hC000, 0, 32'h5678, 1, 0)));
        s.push_back(mk(1, 1, 1, 2'b10, 32'hC004, 0, 32'h1234, 1, 2'b10, 32'hD004, 0, 32'h5678, ex(1, 2'b10, 32'hD004, 0, 32'h1234, 0, 1)));
        s.push_back(mk(1, 1, 1, 2'b10, 32'hC004, 0, 32'h1234, 1, 2'b10, 32'hD008, 0, 32'h5678, ex(1, 2'b10, 32'hC004, 0, 32'h5678, 1, 0)));
`else
        s.push_back(mk(1, 1, 1, 2'b10, 32'hC000, 0, 32'h1234, 1, 2'b10, 32'hD000, 0, 32'h5678, ex(1, 2'b10, 32'hD000, 0, 0, 0, 1)));
        s.push_back(mk(1, 1, 1, 2'b10, 32'hC000, 0, 32'h1234, 1, 2'b10, 32'hD004, 0, 32'h5678, ex(1, 2'b10, 32'hD004, 0, 32'h5678, 0, 1)));
        s.push_back(mk(1, 1, 1, 2'b10, 32'hC000, 0, 32'h1234, 1, 2'b10, 32'hD008, 0, 32'h5678, ex(1, 2'b10, 32'hD008, 0, 32'h5678, 0, 1)));
        s.push_back(mk(1, 1, 1, 2'b10, 32'hC000, 0, 32'h1234, 1, 2'b10, 32'hD00C, 0, 32'h5678, ex(1, 2'b10, 32'hD00C, 0, 32'h5678, 0, 1)));
`endif
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front();
            nchk++;
            if (obs !== e) begin nerr++; $display("FAIL b2b[%0d]: got %h expected %h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        HRESETn = 1'b0; HREADYOUT_S = 1'b1;
        HSEL_ICODE = 0; HTRANS_ICODE = 0; HADDR_ICODE = 0; HWRITE_ICODE = 0; HWDATA_ICODE = 0; HSIZE_ICODE = 3'b010;
        HSEL_DCODE = 0; HTRANS_DCODE = 0; HADDR_DCODE = 0; HWRITE_DCODE = 0; HWDATA_DCODE = 0; HSIZE_DCODE = 3'b010;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        @(posedge clk); #1;
        test_single;
        test_both;
        test_burst;
        test_wait;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
